huffman_bit_packer: RTL and testbench
=====================================

Name: huffman_bit_packer

Overview:
- Downstream stage of the Huffman AC/DC encoder. Takes one symbol per handshake: a Huffman code plus its appended amplitude bits.
- Packs symbols MSB-first into a bit accumulator and emits bytes on a valid/ready stream.
- Inserts a 0x00 stuff byte after every emitted 0xFF, as JPEG entropy-coded segments require.
- On request, pads the final partial byte with 1s and drains the accumulator.

Parameters:
- ACC_W, 64, accumulator width in bits; must be ≥ 54.
- MAX_CODE, 16, maximum Huffman code length in bits.
- MAX_VAL, 11, maximum amplitude length in bits.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  symbol present
- in_ready  out  1  symbol accepted when in_valid && in_ready
- code  in  16  Huffman code, right-aligned
- code_size  in  8  valid bits in code (0..16)
- value  in  16  amplitude bits, right-aligned
- value_len  in  8  valid bits in value (0..11)
- flush_req  in  1  single-cycle pulse: pad and drain
- out_valid  out  1  byte available
- out_ready  in  1  downstream accepts byte
- out_byte  out  8  packed byte
- flush_done  out  1  one-cycle pulse when the flush completes
- byte_count  out  32  bytes emitted, including stuff bytes
- err  out  1  sticky: illegal size was presented

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset values: acc=0, fill=0, stuff_pending=0, state=RUN, out_valid=0, in_ready=1, flush_done=0, byte_count=0, err=0.
- Reset mid-operation discards all buffered bits. No byte or flush_done is produced afterwards.
- Accumulator: acc is MSB-aligned; fill holds the number of valid bits.
- Append on accept: bits {code[code_size-1:0], value[value_len-1:0]} are written at position fill. Then fill += code_size + value_len. Input bits above the stated size are ignored.
- Illegal symbol: code_size > MAX_CODE or value_len > MAX_VAL. The symbol is still accepted (handshake completes) but dropped, and err is set. err clears only on reset.
- in_ready = (state==RUN) && (fill ≤ ACC_W − (MAX_CODE+MAX_VAL)). It is a registered function of current state, with no combinational path from out_ready.
- out_valid = stuff_pending || (fill ≥ 8).
- out_byte = stuff_pending ? 0x00 : acc[ACC_W-1 -: 8].
- out_byte and out_valid hold stable while out_valid && !out_ready.
- On an output handshake:
  - If stuff_pending: clear it.
  - Otherwise: shift acc left by 8 and fill -= 8. If the byte was 0xFF, set stuff_pending.
  - In both cases byte_count += 1, wrapping modulo 2^32.
- Same-cycle input and output: the append uses the post-shift position (fill−8+new bits). At most one byte out and one symbol in per cycle.
- FSM states:
  - RUN: normal operation. flush_req moves to PAD. A symbol accepted in the same cycle as flush_req is included in the flush.
  - PAD: in_ready=0. If fill%8 ≠ 0, fill the low bits up to the next byte boundary with 1s and round fill up. This takes one cycle and may not coincide with an output shift: out_valid is forced 0 in PAD. Then go to DRAIN.
  - DRAIN: in_ready=0. Emit bytes until fill==0 && !stuff_pending. Then pulse flush_done for one cycle and return to RUN.
- flush_req while not in RUN is ignored.
- A flush with an empty accumulator completes in 2 cycles (PAD→DRAIN→RUN) with no bytes emitted.
- Padding 1s can form 0xFF; it is stuffed like any other 0xFF.

Decomposition:
- Shared package jpeg_enc_pkg holds:
  - constants MAX_CODE=16, MAX_VAL=11, STUFF_BYTE=8'h00, MARKER_BYTE=8'hFF;
  - the state enum {RUN, PAD, DRAIN}.
- One natural sub-module: bit_accum_shifter. It is the combinational mask/align/merge of the new symbol into acc at a variable offset, with a shift-by-8 option, and is reused by the DC path.

Test Plan:
- Basic pack and flush: code=4'b1010 (size 4), value=3'b011 (len 3), then flush_req → one byte 0xA7, then flush_done; byte_count=1.
- Stuffing: code=8'hFF (size 8), value_len=0, then flush → bytes 0xFF, 0x00; byte_count=2. Also: a 7-bit all-ones code plus flush pad produces 0xFF, 0x00.
- Backpressure: out_ready=0, two symbols with 16+11 bits each → fill=54 and in_ready drops on the next cycle. Raising out_ready drains 6 bytes and in_ready returns once fill ≤ 37. out_byte holds stable while stalled.
- Simultaneous input and output: sustained 12-bit symbols with out_ready=1 → correct bit order versus a software model over 1000 random symbols, with no lost or duplicated bits.
- Error: code_size=17 → symbol dropped, err=1 and remains 1 afterwards. Later legal symbols pack normally.
- Reset mid-drain: assert reset_n=0 during DRAIN with 3 bytes pending → all outputs return to their reset values, and no flush_done is seen after release.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared constants and types for the JPEG entropy-coding back end.
package jpeg_enc_pkg;
    localparam int         MAX_CODE    = 16;
    localparam int         MAX_VAL     = 11;
    localparam logic [7:0] STUFF_BYTE  = 8'h00;
    localparam logic [7:0] MARKER_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/bit_accum_shifter.sv
// Combinational merge of one masked symbol into an MSB-aligned bit accumulator,
// optionally after consuming the top byte.
module bit_accum_shifter
    import jpeg_enc_pkg::*;
#(
    parameter int ACC_W  = 64,
    parameter int FILL_W = 7,
    parameter int SYM_W  = MAX_CODE + MAX_VAL
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [FILL_W-1:0] i_fill,
    input  logic              i_shift8,
    input  logic              i_append,
    input  logic [15:0]       i_code,
    input  logic [7:0]        i_code_size,
    input  logic [15:0]       i_value,
    input  logic [7:0]        i_value_len,
    output logic [ACC_W-1:0]  o_acc,
    output logic [FILL_W-1:0] o_fill
);
    logic [15:0]       w_code_mask;
    logic [15:0]       w_value_mask;
    logic [SYM_W-1:0]  w_sym;
    logic [7:0]        w_len;
    logic [ACC_W-1:0]  w_acc_s;
    logic [FILL_W-1:0] w_fill_s;
    logic [7:0]        w_pos;
    logic [ACC_W-1:0]  w_sym_ext;

    assign w_code_mask  = 16'((32'd1 << i_code_size) - 32'd1);
    assign w_value_mask = 16'((32'd1 << i_value_len) - 32'd1);
    assign w_sym        = (SYM_W'(i_code & w_code_mask) << i_value_len)
                        | SYM_W'(i_value & w_value_mask);
    assign w_len        = i_code_size + i_value_len;

    // The new symbol lands just below the post-shift fill point.
    assign w_acc_s   = i_shift8 ? (i_acc << 8) : i_acc;
    assign w_fill_s  = i_shift8 ? (i_fill - FILL_W'(8)) : i_fill;
    assign w_pos     = 8'(ACC_W) - 8'(w_fill_s) - w_len;
    assign w_sym_ext = ACC_W'(w_sym) << w_pos;

    assign o_acc  = i_append ? (w_acc_s | w_sym_ext) : w_acc_s;
    assign o_fill = i_append ? (w_fill_s + FILL_W'(w_len)) : w_fill_s;
endmodule

// File: rtl/huffman_bit_packer.sv
// Packs Huffman code + amplitude symbols MSB-first into bytes, with 0xFF
// byte stuffing and a pad-with-ones flush.
module huffman_bit_packer
    import jpeg_enc_pkg::*;
#(
    parameter int ACC_W     = 64,
    parameter int P_MAXCODE = MAX_CODE,
    parameter int P_MAXVAL  = MAX_VAL
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] code,
    input  logic [7:0]  code_size,
    input  logic [15:0] value,
    input  logic [7:0]  value_len,
    input  logic        flush_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        flush_done,
    output logic [31:0] byte_count,
    output logic        err
);
    localparam int FILL_W   = $clog2(ACC_W + 1);
    localparam int IN_LIMIT = ACC_W - (P_MAXCODE + P_MAXVAL);
    localparam logic [ACC_W-1:0] ALL_ONES = '1;

    state_t            r_state, w_state_nxt;
    logic [ACC_W-1:0]  r_acc, w_acc_nxt;
    logic [FILL_W-1:0] r_fill, w_fill_nxt, w_fill_rnd, w_fill_final;
    logic              r_stuff, r_in_ready, r_flush_done, r_err;
    logic [31:0]       r_byte_count;
    logic              w_out_valid, w_pad_en, w_drain_done;
    logic              w_out_fire, w_in_fire, w_legal;
    logic [ACC_W-1:0]  w_pad_mask;

    assign w_legal    = (code_size <= 8'(P_MAXCODE)) && (value_len <= 8'(P_MAXVAL));
    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = w_out_valid && out_ready;

    bit_accum_shifter #(
        .ACC_W (ACC_W),
        .FILL_W(FILL_W),
        .SYM_W (P_MAXCODE + P_MAXVAL)
    ) u_shifter (
        .i_acc      (r_acc),
        .i_fill     (r_fill),
        .i_shift8   (w_out_fire && !r_stuff),
        .i_append   (w_in_fire && w_legal),
        .i_code     (code),
        .i_code_size(code_size),
        .i_value    (value),
        .i_value_len(value_len),
        .o_acc      (w_acc_nxt),
        .o_fill     (w_fill_nxt)
    );

    // Ones between the current fill point and the next byte boundary.
    assign w_fill_rnd   = (r_fill + FILL_W'(7)) & ~FILL_W'(7);
    assign w_pad_mask   = ~(ALL_ONES >> w_fill_rnd) & (ALL_ONES >> r_fill);
    assign w_fill_final = w_pad_en ? w_fill_rnd : w_fill_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (flush_req) w_state_nxt = PAD;
            PAD:     w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_done) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_out_valid  = 1'b0;
        w_pad_en     = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            RUN:   w_out_valid = r_stuff || (r_fill >= FILL_W'(8));
            PAD:   w_pad_en = 1'b1;
            DRAIN: begin
                w_out_valid  = r_stuff || (r_fill >= FILL_W'(8));
                w_drain_done = (r_fill == '0) && !r_stuff;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_stuff      <= 1'b0;
            r_in_ready   <= 1'b1;
            r_flush_done <= 1'b0;
            r_byte_count <= '0;
            r_err        <= 1'b0;
        end else begin
            r_acc        <= w_pad_en ? (r_acc | w_pad_mask) : w_acc_nxt;
            r_fill       <= w_fill_final;
            r_in_ready   <= (w_state_nxt == RUN) && (w_fill_final <= FILL_W'(IN_LIMIT));
            r_flush_done <= w_drain_done;
            if (w_out_fire) begin
                r_stuff      <= !r_stuff && (out_byte == MARKER_BYTE);
                r_byte_count <= r_byte_count + 32'd1;
            end
            if (w_in_fire && !w_legal) r_err <= 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_byte   = r_stuff ? STUFF_BYTE : r_acc[ACC_W-1 -: 8];
    assign flush_done = r_flush_done;
    assign byte_count = r_byte_count;
    assign err        = r_err;
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Scoreboard bench for huffman_bit_packer: directed vectors plus a bit-level model.
module tb_huffman_bit_packer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] code = '0;
    logic [7:0]  code_size = '0;
    logic [15:0] value = '0;
    logic [7:0]  value_len = '0;
    logic        flush_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        flush_done;
    logic [31:0] byte_count;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_count = 0;
    logic [7:0]  exp_q[$];
    bit          mdl_bits[$];
    logic [7:0]  mon_exp;

    always #5 clock = ~clock;

    huffman_bit_packer #(.ACC_W(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .code_size (code_size),
        .value     (value),
        .value_len (value_len),
        .flush_req (flush_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .flush_done(flush_done),
        .byte_count(byte_count),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: every accepted byte must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_byte", 32'(out_byte), 32'(mon_exp));
            end
        end
    end

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_count++;
    endtask

    task automatic send(input logic [15:0] c, input int cs, input logic [15:0] v, input int vl);
        int n;
        in_valid  = 1'b1;
        code      = c;
        code_size = 8'(cs);
        value     = v;
        value_len = 8'(vl);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic do_flush(output int cycles);
        int n;
        in_valid  = 1'b0;
        flush_req = 1'b1;
        @(posedge clock); #1;
        flush_req = 1'b0;
        n = 0;
        while (!flush_done && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        check("flush_done", 32'(flush_done), 32'd1);
        cycles = n;
        @(posedge clock); #1;
        check("flush_done_pulse", 32'(flush_done), 32'd0);
        check("byte_count", byte_count, 32'(exp_count));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_byte_count", byte_count, 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic model_emit();
        logic [7:0] b;
        while (mdl_bits.size() >= 8) begin
            for (int k = 7; k >= 0; k--) b[k] = mdl_bits.pop_front();
            expect_byte(b);
            if (b == 8'hFF) expect_byte(8'h00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int cs;
        logic [15:0] rc, rv;

        repeat (3) @(posedge clock);
        #1;
        check_reset_values();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;

        // Basic: 1010 + 011 + one pad bit -> 0xA7
        expect_byte(8'hA7);
        send(16'h000A, 4, 16'h0003, 3);
        in_valid = 1'b0;
        do_flush(cyc);

        // Stuffing of a full 0xFF code, then of a 0xFF completed by padding
        expect_byte(8'hFF);
        expect_byte(8'h00);
        send(16'h00FF, 8, 16'hFFFF, 0);
        in_valid = 1'b0;
        do_flush(cyc);
        expect_byte(8'hFF);
        expect_byte(8'h00);
        send(16'hFF7F, 7, 16'h1234, 0);
        in_valid = 1'b0;
        do_flush(cyc);

        // Empty flush: PAD then DRAIN, done pulse two cycles after the request
        do_flush(cyc);
        check("empty_flush_cycles", 32'(cyc), 32'd2);

        // Backpressure: two maximal 27-bit symbols fill 54 bits
        out_ready = 1'b0;
        expect_byte(8'h84); expect_byte(8'h21); expect_byte(8'hB4); expect_byte(8'hB0);
        expect_byte(8'h84); expect_byte(8'h36); expect_byte(8'h97);
        send(16'h8421, 16, 16'h05A5, 11);
        check("in_ready_after_first", 32'(in_ready), 32'd1);
        send(16'h8421, 16, 16'h05A5, 11);
        in_valid = 1'b0;
        check("in_ready_full", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'h84);
        repeat (4) begin @(posedge clock); #1; end
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_byte", 32'(out_byte), 32'h84);
        check("stall_no_count", byte_count, 32'(exp_count - 7));
        out_ready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("in_ready_fill38", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("in_ready_fill30", 32'(in_ready), 32'd1);
        do_flush(cyc);

        // Illegal sizes are consumed, dropped and make err sticky
        send(16'hFFFF, 17, 16'h0000, 0);
        in_valid = 1'b0;
        check("err_code_size", 32'(err), 32'd1);
        send(16'h000F, 4, 16'h0FFF, 12);
        expect_byte(8'hA5);
        send(16'h00A5, 8, 16'h0000, 0);
        in_valid = 1'b0;
        check("err_sticky", 32'(err), 32'd1);
        do_flush(cyc);

        // Sustained 12-bit symbols against the bit-level model
        for (int i = 0; i < 1000; i++) begin
            cs = int'($urandom_range(1, 12));
            rc = 16'($urandom);
            rv = 16'($urandom);
            for (int k = cs - 1; k >= 0; k--) mdl_bits.push_back(rc[k]);
            for (int k = 11 - cs; k >= 0; k--) mdl_bits.push_back(rv[k]);
            model_emit();
            send(rc, cs, rv, 12 - cs);
        end
        in_valid = 1'b0;
        while ((mdl_bits.size() % 8) != 0) mdl_bits.push_back(1'b1);
        model_emit();
        do_flush(cyc);

        // Reset during DRAIN with three bytes held back
        out_ready = 1'b0;
        send(16'h1234, 16, 16'h0056, 8);
        in_valid  = 1'b0;
        flush_req = 1'b1;
        @(posedge clock); #1;
        flush_req = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("drain_pending_valid", 32'(out_valid), 32'd1);
        check("drain_pending_byte", 32'(out_byte), 32'h12);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            check("post_reset_no_done", 32'(flush_done), 32'd0);
            check("post_reset_no_valid", 32'(out_valid), 32'd0);
        end
        check("post_reset_count", byte_count, 32'd0);

        // Normal operation resumes after reset
        expect_byte(8'hA7);
        send(16'hFFFA, 4, 16'hFFFB, 3);
        in_valid = 1'b0;
        do_flush(cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
